// File: rtl/xor128_prng_bank_pkg.sv
// Shared types, FSM encodings, default seed and xorshift128 step helpers
// for the xorshift128 PRNG bank.
package xor128_prng_bank_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_SEEDING = 2'd0;
  localparam logic [STATE_W-1:0] ST_WARMUP  = 2'd1;
  localparam logic [STATE_W-1:0] ST_RUN     = 2'd2;

  localparam logic [WORD_W-1:0] DEF_SEED0 = 32'd123456789;
  localparam logic [WORD_W-1:0] DEF_SEED1 = 32'd362436069;
  localparam logic [WORD_W-1:0] DEF_SEED2 = 32'd521288629;
  localparam logic [WORD_W-1:0] DEF_SEED3 = 32'd88675123;

  // x sits in the low word so a {w3,w2,w1,w0} seed casts straight onto it
  typedef struct packed {
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] z;
    logic [WORD_W-1:0] y;
    logic [WORD_W-1:0] x;
  } xs_state_t;

  function automatic logic [WORD_W-1:0] xs_next_word(input logic [WORD_W-1:0] x,
                                                     input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] t;
    t = x ^ (x << 11);
    return w ^ (w >> 19) ^ t ^ (t >> 8);
  endfunction

  function automatic xs_state_t xs_step(input xs_state_t s);
    xs_state_t n;
    n.x = s.y;
    n.y = s.z;
    n.z = s.w;
    n.w = xs_next_word(s.x, s.w);
    return n;
  endfunction

endpackage

// File: rtl/xor128_lane.sv
// One xorshift128 lane: slot-wise load during seeding, single step otherwise.
module xor128_lane
  import xor128_prng_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [1:0]        load_slot,
  input  logic [WORD_W-1:0] load_word,
  input  logic              step_en,
  output logic [WORD_W-1:0] w_o
);

  xs_state_t st_q;
  xs_state_t st_d;

  always_comb begin : lane_next
    st_d = st_q;
    if (load_en) begin
      case (load_slot)
        2'd0:    st_d.x = load_word;
        2'd1:    st_d.y = load_word;
        2'd2:    st_d.z = load_word;
        default: st_d.w = load_word;
      endcase
    end else if (step_en) begin
      st_d = xs_step(st_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : lane_reg
    if (!rst_n) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign w_o = st_q.w;

endmodule

// File: rtl/xor128_prng_bank.sv
// Bank of SIZE xorshift128 lanes seeded serially from one chain generator,
// optionally warmed up, then stepped in lockstep on each accepted output.
module xor128_prng_bank
  import xor128_prng_bank_pkg::*;
#(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned WARMUP = 16,
  parameter logic [31:0] SEED0  = DEF_SEED0,
  parameter logic [31:0] SEED1  = DEF_SEED1,
  parameter logic [31:0] SEED2  = DEF_SEED2,
  parameter logic [31:0] SEED3  = DEF_SEED3
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iSeedValid,
  input  logic [127:0]         iSeed,
  output logic [SIZE*32-1:0]   oRand,
  output logic                 oValid,
  input  logic                 iReady,
  output logic                 oBusy
);

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned LANE_W = CNT_W - 2;
  localparam logic [CNT_W-1:0] SEED_LAST = CNT_W'(4 * SIZE - 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP == 0) ? 0 : WARMUP - 1);
  localparam xs_state_t        SEED_DEF  = {SEED3, SEED2, SEED1, SEED0};

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  xs_state_t          chain_q, chain_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  xs_state_t          seed_c;
  logic [WORD_W-1:0]  new_word_c;
  logic               seed_wr_c;
  logic               lane_step_c;

  // All-zero seeds would lock xorshift at zero forever
  assign seed_c     = (iSeed == '0) ? SEED_DEF : xs_state_t'(iSeed);
  assign new_word_c = xs_next_word(chain_q.x, chain_q.w);

  always_comb begin : fsm_next
    state_d     = state_q;
    cnt_d       = cnt_q;
    chain_d     = chain_q;
    seed_wr_c   = 1'b0;
    lane_step_c = 1'b0;
    if (iSeedValid) begin
      state_d = ST_SEEDING;
      cnt_d   = '0;
      chain_d = seed_c;
    end else begin
      case (state_q)
        ST_SEEDING: begin
          seed_wr_c = 1'b1;
          chain_d   = xs_step(chain_q);
          if (cnt_q == SEED_LAST) begin
            cnt_d   = '0;
            state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WARMUP: begin
          lane_step_c = 1'b1;
          if (cnt_q == WARM_LAST) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          lane_step_c = iReady;
        end
        default: begin
          state_d = ST_SEEDING;
          cnt_d   = '0;
          chain_d = SEED_DEF;
        end
      endcase
    end
    valid_d = (state_d == ST_RUN);
    busy_d  = ~valid_d;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin : fsm_reg
    if (!iRst_n) begin
      state_q <= ST_SEEDING;
      cnt_q   <= '0;
      chain_q <= SEED_DEF;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chain_q <= chain_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Chain word n lands in lane n/4, slot n%4
  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    logic [WORD_W-1:0] lane_w;
    logic              lane_load;

    assign lane_load = seed_wr_c && (cnt_q[CNT_W-1:2] == LANE_W'(k));

    xor128_lane u_lane (
      .clk       (iClk),
      .rst_n     (iRst_n),
      .load_en   (lane_load),
      .load_slot (cnt_q[1:0]),
      .load_word (new_word_c),
      .step_en   (lane_step_c),
      .w_o       (lane_w)
    );

    assign oRand[k*32 +: 32] = lane_w;
  end

  assign oValid = valid_q;
  assign oBusy  = busy_q;

endmodule

// File: tb/tb_xor128_prng_bank.sv
// Scoreboard bench for xor128_prng_bank: three configurations share one clock
// and reset; expected words come from hand constants and a reference generator.
module tb_xor128_prng_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         sv1, sv2, sv8;
  logic [127:0] seed1, seed2, seed8;
  logic         rdy1, rdy2, rdy8;
  logic [31:0]  rand1;
  logic [63:0]  rand2;
  logic [255:0] rand8;
  logic         valid1, valid2, valid8;
  logic         busy1, busy2, busy8;

  xor128_prng_bank #(.SIZE(1), .WARMUP(0)) u_d1 (
    .iClk(clk), .iRst_n(rst_n), .iSeedValid(sv1), .iSeed(seed1),
    .oRand(rand1), .oValid(valid1), .iReady(rdy1), .oBusy(busy1)
  );

  xor128_prng_bank #(.SIZE(2), .WARMUP(0)) u_d2 (
    .iClk(clk), .iRst_n(rst_n), .iSeedValid(sv2), .iSeed(seed2),
    .oRand(rand2), .oValid(valid2), .iReady(rdy2), .oBusy(busy2)
  );

  xor128_prng_bank #(.SIZE(8), .WARMUP(16)) u_d8 (
    .iClk(clk), .iRst_n(rst_n), .iSeedValid(sv8), .iSeed(seed8),
    .oRand(rand8), .oValid(valid8), .iReady(rdy8), .oBusy(busy8)
  );

  localparam logic [127:0] DEF_SEED = {32'd88675123, 32'd521288629, 32'd362436069, 32'd123456789};
  localparam logic [127:0] ALT_SEED = {32'h0badf00d, 32'h13579bdf, 32'h2468ace0, 32'hdeadbeef};

  int checks = 0;
  int errors = 0;
  logic [255:0] q1[$];
  logic [255:0] q2[$];
  logic [255:0] q8[$];
  logic [31:0]  gm[64];

  // Reference xorshift128: gm[i] is the i-th generated word after the seed
  task automatic model_gen(input logic [127:0] seed);
    logic [31:0] x, y, z, w, t, n;
    {w, z, y, x} = seed;
    for (int i = 0; i < 64; i++) begin
      t = x ^ (x << 11);
      n = w ^ (w >> 19) ^ t ^ (t >> 8);
      x = y; y = z; z = w; w = n;
      gm[i] = n;
    end
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push2(input int j);
    q2.push_back(256'({gm[7+j], gm[3+j]}));
  endtask

  task automatic push8(input int j);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = gm[4*k + 19 + j];
    q8.push_back(v);
  endtask

  task automatic push1_restart();
    q1.push_back(256'(32'd3633119408));
    q1.push_back(256'(32'd516391518));
    q1.push_back(256'(32'd2377269574));
  endtask

  // Runs from posedge+1; each ready drops once its queue has been drained
  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (q1.size() == 0) rdy1 = 1'b0;
      if (q2.size() == 0) rdy2 = 1'b0;
      if (q8.size() == 0) rdy8 = 1'b0;
    end
    checks++;
    if (q1.size() + q2.size() + q8.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d/%0d/%0d required=0/0/0", q1.size(), q2.size(), q8.size());
      q1.delete(); q2.delete(); q8.delete();
      rdy1 = 1'b0; rdy2 = 1'b0; rdy8 = 1'b0;
    end
  endtask

  // Monitor: every accepted transfer pops and compares one expected word set
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (valid1 && rdy1 && !sv1) begin
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL d1_unexpected actual=%0d required=none", rand1);
          end else check("d1_word", 256'(rand1), q1.pop_front());
        end
        if (valid2 && rdy2 && !sv2) begin
          if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL d2_unexpected actual=%0d required=none", rand2);
          end else check("d2_word", 256'(rand2), q2.pop_front());
        end
        if (valid8 && rdy8 && !sv8) begin
          if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL d8_unexpected actual=%0d required=none", rand8);
          end else check("d8_word", rand8, q8.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first1, first2, first8;
    rst_n = 1'b0;
    sv1 = 1'b0; sv2 = 1'b0; sv8 = 1'b0;
    seed1 = '0; seed2 = '0; seed8 = '0;
    rdy1 = 1'b0; rdy2 = 1'b0; rdy8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rand1", 256'(rand1), '0);
    check("rst_rand8", rand8, '0);
    check("rst_valid1", 256'(valid1), 256'(1'b0));
    check("rst_busy8", 256'(busy8), 256'(1'b1));

    model_gen(DEF_SEED);
    rst_n = 1'b1;
    first1 = 0; first2 = 0; first8 = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (valid1 && first1 == 0) first1 = c;
      if (valid2 && first2 == 0) first2 = c;
      if (!busy8 && first8 == 0) first8 = c;
    end
    check("d1_first_valid", 256'(first1), 256'(4));
    check("d2_first_valid", 256'(first2), 256'(8));
    check("d8_busy_cycles", 256'(first8), 256'(48));
    check("d8_valid_run", 256'(valid8), 256'(1'b1));

    // No acceptance: outputs must hold
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("d1_hold", 256'(rand1), 256'(32'd3633119408));
      check("d2_hold", 256'(rand2), 256'({gm[7], gm[3]}));
    end

    push1_restart();
    q1.push_back(256'(gm[6]));
    q1.push_back(256'(gm[7]));
    for (int j = 0; j < 4; j++) push2(j);
    for (int j = 0; j < 3; j++) push8(j);
    rdy1 = 1'b1; rdy2 = 1'b1; rdy8 = 1'b1;
    drain(20);

    // Zero-seed reseed while iReady is high: output dropped, sequence restarts
    sv1 = 1'b1; seed1 = '0; rdy1 = 1'b1;
    @(posedge clk); #1;
    check("d1_valid_drop", 256'(valid1), 256'(1'b0));
    sv1 = 1'b0;
    push1_restart();
    q1.push_back(256'(gm[6]));
    q1.push_back(256'(gm[7]));
    drain(20);

    // Explicit nonzero seed on the two-lane bank
    sv2 = 1'b1; seed2 = ALT_SEED;
    @(posedge clk); #1;
    check("d2_valid_drop", 256'(valid2), 256'(1'b0));
    check("d2_busy_seed", 256'(busy2), 256'(1'b1));
    sv2 = 1'b0;
    model_gen(ALT_SEED);
    for (int j = 0; j < 3; j++) push2(j);
    rdy2 = 1'b1;
    drain(20);

    // Asynchronous reset mid-run discards everything
    model_gen(DEF_SEED);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rand8", rand8, '0);
    check("midrst_rand1", 256'(rand1), '0);
    check("midrst_valid8", 256'(valid8), 256'(1'b0));
    check("midrst_busy1", 256'(busy1), 256'(1'b1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    push1_restart();
    push8(0);
    push8(1);
    rdy1 = 1'b1; rdy8 = 1'b1;
    drain(70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor128_prng_bank.md
XOR128_PRNG_BANK -- requirements
Module: xor128_prng_bank

Interface
REQ-001 Parameter SIZE, default 8: number of independent xorshift128 lanes (1..64).
REQ-002 Parameter WARMUP, default 16: lane steps discarded after every seeding (0..255).
REQ-003 Parameters SEED0..SEED3, defaults 123456789, 362436069, 521288629, 88675123: seed used at reset and as the zero-seed substitute.
REQ-004 Port iClk  input  1  clock; all state changes on its rising edge.
REQ-005 Port iRst_n  input  1  asynchronous, active-low reset.
REQ-006 Port iSeedValid  input  1  request to reseed from iSeed; single-cycle pulse sampled each cycle.
REQ-007 Port iSeed  input  128  new seed words {w3,w2,w1,w0}, with w0 at bits [31:0].
REQ-008 Port oRand  output  SIZE*32  lane k output on [k*32+:32].
REQ-009 Port oValid  output  1  oRand holds a valid word set.
REQ-010 Port iReady  input  1  consumer accepts oRand when oValid && iReady.
REQ-011 Port oBusy  output  1  high in SEEDING or WARMUP.

Function
REQ-012 Lane step: t = x ^ (x<<11); new state (x,y,z,w) = (y, z, w, w ^ (w>>19) ^ t ^ (t>>8)), all 32-bit with truncation.
REQ-013 oRand lane k SHALL be the lane's current w register, with no combinational path from inputs.
REQ-014 FSM states: SEEDING, WARMUP, RUN.
REQ-015 SEEDING: the chain registers (a,b,c,d) start at the seed words. Each cycle the block generates word n = step applied to the chain, shifts it into the chain, and writes it to lane n/4, slot n%4 (slot 0=x .. 3=w). The state lasts exactly 4*SIZE cycles.
REQ-016 WARMUP: all lanes step in parallel once per cycle for WARMUP cycles. If WARMUP=0 the state is skipped.
REQ-017 RUN: oValid=1. On a cycle where oValid && iReady, all lanes step and the new w appears on oRand the next cycle. Without acceptance, oRand holds.
REQ-018 iSeedValid in any state: the FSM enters SEEDING next cycle using iSeed, and oValid falls that cycle. The pending oRand is dropped even if iReady was high the same cycle.
REQ-019 An all-zero iSeed SHALL be replaced by SEED0..SEED3.
REQ-020 SEEDING counter wraps: after word 4*SIZE-1 the FSM leaves SEEDING. There is no partial-lane state.
REQ-021 oBusy = (state != RUN); oValid = (state == RUN).

Reset
REQ-022 On iRst_n low: the FSM enters SEEDING with the chain loaded from SEED0..SEED3, counters go to 0, all lane registers go to 0, oValid=0, oBusy=1, oRand=0.
REQ-023 After iRst_n rises, seeding runs automatically. oValid first rises 4*SIZE+WARMUP cycles after the first active edge.
REQ-024 Reset asserted mid-SEEDING or mid-RUN discards all state immediately.

Structure
REQ-025 A shared package SHALL hold the FSM state enumeration, the xorshift128 step function, and the default seed constants.
REQ-026 A single sub-module xor128_lane SHALL hold one lane's state and step logic, with load-slot and step enables. The top SHALL instantiate SIZE of them plus the seeding chain and FSM.

Verification
REQ-027 SIZE=1, WARMUP=0, reset release: oValid rises at cycle 4. oRand=3633119408. Lane state = (3701687786, 458299110, 2500872618, 3633119408).
REQ-028 Same config, iReady=1 for two cycles: oRand goes 516391518, then 2377269574.
REQ-029 SIZE=2, WARMUP=0: lane1 w = 8th chain word. Checked against a software model generating 8 words.
REQ-030 iReady=0 for 10 RUN cycles: oRand is stable and no lane advances.
REQ-031 iSeedValid with iSeed=0 in RUN, same cycle as iReady=1: oValid falls next cycle. The output sequence then restarts identical to REQ-027.
REQ-032 SIZE=8, WARMUP=16: oBusy is high for exactly 48 cycles after reset. The first oRand matches a software model advanced 16 steps.
